// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared arbiter state encoding, default watchdog timeout and master index constants
package bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_HANDOVER} state_t;
  localparam int DEF_TIMEOUT = 16;
  localparam int MASTER_CPU = 0;
  localparam int MASTER_DMA = 1;
endpackage

// File: rtl/bus_rr_picker.sv
// bus_rr_picker: combinational round-robin select of the first requester at or after ptr
module bus_rr_picker #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [2*N-1:0] w_rot;
  // doubling the vector lets a plain shift do the wrap-around
  assign w_rot = {req, req} >> ptr;
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        idx   = (int'(ptr) + k >= N) ? W'(int'(ptr) + k - N) : W'(int'(ptr) + k);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with handover dead cycle, transaction watchdog and error log
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] bus_req,
  output logic [MASTERS-1:0] bus_grant,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic               fc_bus,
  output logic               watchdog,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic               err_valid,
  output logic [IDX_W-1:0]   err_master,
  input  logic               err_clr
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_ptr;
  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic               w_active;
  logic               w_fire;
  logic               w_release;
  logic [MASTERS-1:0] w_onehot;

  bus_rr_picker #(.N(MASTERS), .W(IDX_W)) u_pick (
    .req  (bus_req),
    .ptr  (r_ptr),
    .found(w_found),
    .idx  (w_idx)
  );

  assign w_active  = rd_bus | wr_bus;
  // an ack arriving in the final cycle suppresses the abort
  assign w_fire    = (r_state == ST_GRANTED) && w_active && !fc_bus && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_release = w_fire || (!(|(bus_req & bus_grant)) && !w_active);
  assign w_onehot  = MASTERS'(1) << w_idx;
  assign watchdog  = w_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      bus_grant  <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      err_valid  <= 1'b0;
      err_master <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            bus_grant <= w_onehot;
            owner     <= w_idx;
            busy      <= 1'b1;
            r_state   <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (w_release) begin
            bus_grant <= '0;
            busy      <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= (owner == IDX_W'(MASTERS - 1)) ? '0 : owner + 1'b1;
            r_state   <= ST_HANDOVER;
          end else begin
            r_cnt <= (!w_active || fc_bus) ? '0 : r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
      if (w_fire && (!err_valid || err_clr)) begin
        err_valid  <= 1'b1;
        err_master <= owner;
      end else if (err_clr) begin
        err_valid  <= 1'b0;
        err_master <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenario tests for bus_arbiter with hand-computed expectations
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bus_req;
  logic [3:0] bus_grant;
  logic       rd_bus, wr_bus, fc_bus, err_clr;
  logic       watchdog, busy, err_valid;
  logic [2:0] owner, err_master;
  int checks = 0;
  int errors = 0;

  bus_arbiter #(.MASTERS(4), .TIMEOUT(16), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .rd_bus    (rd_bus),
    .wr_bus    (wr_bus),
    .fc_bus    (fc_bus),
    .watchdog  (watchdog),
    .owner     (owner),
    .busy      (busy),
    .err_valid (err_valid),
    .err_master(err_master),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_req = '0; rd_bus = 0; wr_bus = 0; fc_bus = 0; err_clr = 0;
    #2 rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic wait_grant(input logic [3:0] g, input string name);
    int n;
    n = 0;
    while (bus_grant !== g && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus_grant !== g) begin
      errors++;
      $display("FAIL %s: grant=%b expected %b", name, bus_grant, g);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus_grant, busy, owner, watchdog, err_valid, err_master} !== 13'b0) begin
      errors++;
      $display("FAIL reset: grant=%b busy=%b owner=%0d wd=%b ev=%b em=%0d expected all zero",
               bus_grant, busy, owner, watchdog, err_valid, err_master);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus_req = 4'b0010;
    tick();
    checks++;
    if (bus_grant !== 4'b0010 || owner !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b owner=%0d busy=%b expected 0010 1 1", bus_grant, owner, busy);
    end
    repeat (5) tick();
    bus_req = 4'b0000;
    tick();
    checks++;
    if (bus_grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drop: grant=%b busy=%b expected 0000 0", bus_grant, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    bus_req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      checks++;
      if (bus_grant !== exp || owner !== 3'(i % 4)) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b owner=%0d expected %b %0d", i, bus_grant, owner, exp, i % 4);
      end
      repeat (3) tick();
      checks++;
      if (bus_grant !== exp) begin
        errors++;
        $display("FAIL rr_no_preempt%0d: grant=%b expected %b", i, bus_grant, exp);
      end
      bus_req = bus_req & ~exp;
      tick();
      checks++;
      if (bus_grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_handover%0d: grant=%b expected 0000", i, bus_grant);
      end
      bus_req = 4'b1111;
      tick();
      checks++;
      if (bus_grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_idle%0d: grant=%b expected 0000", i, bus_grant);
      end
      tick();
    end
  endtask

  task automatic test_hold_on_wr();
    do_reset();
    bus_req = 4'b0001;
    tick();
    wr_bus = 1; fc_bus = 0;
    tick();
    bus_req = 4'b0000;
    repeat (3) tick();
    checks++;
    if (bus_grant !== 4'b0001) begin
      errors++;
      $display("FAIL hold_on_wr: grant=%b expected 0001", bus_grant);
    end
    fc_bus = 1;
    tick();
    wr_bus = 0; fc_bus = 0;
    tick();
    checks++;
    if (bus_grant !== 4'b0000) begin
      errors++;
      $display("FAIL release_after_wr: grant=%b expected 0000", bus_grant);
    end
  endtask

  task automatic run_timeout(input string name);
    rd_bus = 1;
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if (watchdog !== 1'b0) begin
        errors++;
        $display("FAIL %s_early: cycle %0d watchdog=%b expected 0", name, i + 1, watchdog);
      end
      tick();
    end
    #1;
    checks++;
    if (watchdog !== 1'b1) begin
      errors++;
      $display("FAIL %s_fire: watchdog=%b expected 1", name, watchdog);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus_req = 4'b0010;
    wait_grant(4'b0010, "to_grant");
    run_timeout("to1");
    tick();
    rd_bus = 0;
    checks++;
    if (bus_grant !== 4'b0000 || watchdog !== 1'b0 || err_valid !== 1'b1 || err_master !== 3'd1) begin
      errors++;
      $display("FAIL to1_after: grant=%b wd=%b ev=%b em=%0d expected 0000 0 1 1",
               bus_grant, watchdog, err_valid, err_master);
    end
  endtask

  task automatic test_err_log();
    bus_req = 4'b0100;
    wait_grant(4'b0100, "err_grant2");
    run_timeout("to2");
    tick();
    rd_bus = 0;
    checks++;
    if (err_valid !== 1'b1 || err_master !== 3'd1) begin
      errors++;
      $display("FAIL err_sticky: ev=%b em=%0d expected 1 1", err_valid, err_master);
    end
    wait_grant(4'b0100, "err_grant3");
    run_timeout("to3");
    err_clr = 1;
    tick();
    err_clr = 0;
    rd_bus = 0;
    checks++;
    if (err_valid !== 1'b1 || err_master !== 3'd2) begin
      errors++;
      $display("FAIL err_clr_fire: ev=%b em=%0d expected 1 2", err_valid, err_master);
    end
    err_clr = 1;
    tick();
    err_clr = 0;
    checks++;
    if (err_valid !== 1'b0 || err_master !== 3'd0) begin
      errors++;
      $display("FAIL err_clr: ev=%b em=%0d expected 0 0", err_valid, err_master);
    end
    bus_req = 4'b0000;
  endtask

  task automatic test_fc_ack();
    do_reset();
    bus_req = 4'b0010;
    wait_grant(4'b0010, "fc_grant");
    rd_bus = 1;
    repeat (15) tick();
    fc_bus = 1;
    #1;
    checks++;
    if (watchdog !== 1'b0) begin
      errors++;
      $display("FAIL fc_win: watchdog=%b expected 0", watchdog);
    end
    tick();
    fc_bus = 0; rd_bus = 0;
    checks++;
    if (bus_grant !== 4'b0010 || err_valid !== 1'b0) begin
      errors++;
      $display("FAIL fc_retain: grant=%b ev=%b expected 0010 0", bus_grant, err_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_req = 4'b0100;
    wait_grant(4'b0100, "rm_grant");
    rd_bus = 1;
    repeat (15) tick();
    #2 rst = 1;
    #1;
    checks++;
    if (bus_grant !== 4'b0000 || watchdog !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: grant=%b wd=%b busy=%b expected 0000 0 0", bus_grant, watchdog, busy);
    end
    tick();
    rst = 0;
    rd_bus = 0;
    bus_req = 4'b0000;
  endtask

  initial begin
    rst = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_on_wr();
    test_timeout();
    test_err_log();
    test_fc_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
